// File: rtl/alu_mc_pkg.sv
// alu_mc shared opcodes, FSM encodings and widths.
// Divider build switch: ALU_MC_DIV_EN.
package alu_mc_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] ALU_ADD   = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB   = 5'd1;
  localparam logic [OP_W-1:0] ALU_AND   = 5'd2;
  localparam logic [OP_W-1:0] ALU_OR    = 5'd3;
  localparam logic [OP_W-1:0] ALU_XOR   = 5'd4;
  localparam logic [OP_W-1:0] ALU_SLT   = 5'd5;
  localparam logic [OP_W-1:0] ALU_SLTU  = 5'd6;
  localparam logic [OP_W-1:0] ALU_SGE   = 5'd7;
  localparam logic [OP_W-1:0] ALU_SGEU  = 5'd8;
  localparam logic [OP_W-1:0] ALU_SNE   = 5'd9;
  localparam logic [OP_W-1:0] ALU_MUL   = 5'd10;
  localparam logic [OP_W-1:0] ALU_MULH  = 5'd11;
  localparam logic [OP_W-1:0] ALU_MULHU = 5'd12;
  localparam logic [OP_W-1:0] ALU_DIV   = 5'd13;
  localparam logic [OP_W-1:0] ALU_DIVU  = 5'd14;
  localparam logic [OP_W-1:0] ALU_REM   = 5'd15;
  localparam logic [OP_W-1:0] ALU_REMU  = 5'd16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_mc_mdu_iter.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up.
// Divider datapath present only with ALU_MC_DIV_EN.
module mdu_iter
  import alu_mc_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int BITS_PER_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start,
  input  logic              is_div,
  input  logic              sgn,
  input  logic              sel_hi,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              last,
  output logic [DATA_W-1:0] res
);

  localparam int N  = DATA_W / BITS_PER_CYC;
  localparam int CW = $clog2(N);
  localparam int W2 = 2 * DATA_W;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              div_q, div_d;
  logic              hi_q, hi_d;
  logic              neg_q, neg_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [W2-1:0]     st_acc, st_mcand;
  logic [DATA_W-1:0] st_mplier;
  logic [W2-1:0]     prod;
  logic [DATA_W-1:0] mul_res, div_res;

  assign a_neg = sgn & a[DATA_W-1];
  assign b_neg = sgn & b[DATA_W-1];
  assign mag_a = a_neg ? (~a + 1'b1) : a;
  assign mag_b = b_neg ? (~b + 1'b1) : b;
  assign last  = run_q & (cnt_q == CW'(N - 1));

`ifdef ALU_MC_DIV_EN
  logic              rneg_q, rneg_d;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] qq;
  logic [DATA_W:0]   rw;
  logic [DATA_W:0]   dvs;
`endif

  always_comb begin
    st_acc    = acc_q;
    st_mcand  = mcand_q << BITS_PER_CYC;
    st_mplier = mplier_q >> BITS_PER_CYC;
    for (int k = 0; k < BITS_PER_CYC; k++) begin
      if (mplier_q[k]) st_acc = st_acc + (mcand_q << k);
    end
`ifdef ALU_MC_DIV_EN
    r   = acc_q[DATA_W-1:0];
    qq  = mplier_q;
    rw  = '0;
    dvs = {1'b0, mcand_q[DATA_W-1:0]};
    // dividend bits shift out of the quotient register's top
    for (int k = 0; k < BITS_PER_CYC; k++) begin
      rw = {r, qq[DATA_W-1]};
      qq = {qq[DATA_W-2:0], 1'b0};
      if (rw >= dvs) begin
        rw    = rw - dvs;
        qq[0] = 1'b1;
      end
      r = rw[DATA_W-1:0];
    end
    if (div_q) begin
      st_acc    = {{DATA_W{1'b0}}, r};
      st_mcand  = mcand_q;
      st_mplier = qq;
    end
`endif
  end

  always_comb begin
    cnt_d    = cnt_q;
    run_d    = run_q;
    div_d    = div_q;
    hi_d     = hi_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef ALU_MC_DIV_EN
    rneg_d   = rneg_q;
`endif
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      div_d = is_div;
      hi_d  = sel_hi;
      neg_d = a_neg ^ b_neg;
      acc_d = '0;
`ifdef ALU_MC_DIV_EN
      rneg_d = a_neg;
`endif
      if (is_div) begin
        mcand_d  = {{DATA_W{1'b0}}, mag_b};
        mplier_d = mag_a;
      end else begin
        mcand_d  = {{DATA_W{1'b0}}, mag_a};
        mplier_d = mag_b;
      end
    end else if (run_q) begin
      if (flush || last) run_d = 1'b0;
      cnt_d    = cnt_q + CW'(1);
      acc_d    = st_acc;
      mcand_d  = st_mcand;
      mplier_d = st_mplier;
    end
  end

  always_comb begin
    prod    = neg_q ? (~st_acc + 1'b1) : st_acc;
    mul_res = hi_q ? prod[W2-1:DATA_W] : prod[DATA_W-1:0];
`ifdef ALU_MC_DIV_EN
    if (hi_q)
      div_res = rneg_q ? (~st_acc[DATA_W-1:0] + 1'b1) : st_acc[DATA_W-1:0];
    else
      div_res = neg_q ? (~st_mplier + 1'b1) : st_mplier;
`else
    div_res = '0;
`endif
    res = div_q ? div_res : mul_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      run_q    <= 1'b0;
      div_q    <= 1'b0;
      hi_q     <= 1'b0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      div_q    <= div_d;
      hi_q     <= hi_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

`ifdef ALU_MC_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rneg_q <= 1'b0;
    else        rneg_q <= rneg_d;
  end
`endif

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked execute ALU: FSM, handshakes, single-cycle ops.
// ALU_MC_DIV_EN enables the iterative DIV/DIVU/REM/REMU path.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int BITS_PER_CYC = 1,
  parameter int ALU_OP_W     = OP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   opp_a,
  input  logic [DATA_W-1:0]   opp_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   eval,
  output logic                zero,
  output logic                busy
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] eval_q, eval_d;
  logic              zero_q, zero_d;

  logic [OP_W-1:0]   opc;
  logic              accept;
  logic              is_mul, is_div, is_rem, is_sgn;
  logic              iter, start;
  logic [DATA_W-1:0] sc_res, early_res, acc_res;
  logic              early;
  logic              slt, sltu;
  logic              mdu_last;
  logic [DATA_W-1:0] mdu_res;

  assign opc    = OP_W'(op);
  assign is_mul = (opc == ALU_MUL) | (opc == ALU_MULH) |
                  (opc == ALU_MULHU);
  assign is_div = (opc == ALU_DIV) | (opc == ALU_DIVU) |
                  (opc == ALU_REM) | (opc == ALU_REMU);
  assign is_rem = (opc == ALU_REM) | (opc == ALU_REMU);
  assign is_sgn = (opc == ALU_MUL) | (opc == ALU_MULH) |
                  (opc == ALU_DIV) | (opc == ALU_REM);

  assign in_ready  = (state_q == ST_IDLE) |
                     ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC);
  assign eval      = eval_q;
  assign zero      = zero_q;

  assign slt  = $signed(opp_a) < $signed(opp_b);
  assign sltu = opp_a < opp_b;

  always_comb begin
    sc_res = '0;
    unique case (1'b1)
      (opc == ALU_ADD):  sc_res = opp_a + opp_b;
      (opc == ALU_SUB):  sc_res = opp_a - opp_b;
      (opc == ALU_AND):  sc_res = opp_a & opp_b;
      (opc == ALU_OR):   sc_res = opp_a | opp_b;
      (opc == ALU_XOR):  sc_res = opp_a ^ opp_b;
      (opc == ALU_SLT):  sc_res = {{(DATA_W-1){1'b0}}, slt};
      (opc == ALU_SLTU): sc_res = {{(DATA_W-1){1'b0}}, sltu};
      (opc == ALU_SGE):  sc_res = {{(DATA_W-1){1'b0}}, ~slt};
      (opc == ALU_SGEU): sc_res = {{(DATA_W-1){1'b0}}, ~sltu};
      (opc == ALU_SNE):  sc_res = {{(DATA_W-1){1'b0}}, opp_a != opp_b};
      default:           sc_res = '0;
    endcase
  end

`ifdef ALU_MC_DIV_EN
  logic div_zero, div_ovf;
  assign div_zero = (opp_b == '0);
  // most-negative / -1 overflows the quotient; resolve without iterating
  assign div_ovf  = is_sgn & (opp_a == {1'b1, {(DATA_W-1){1'b0}}}) &
                    (opp_b == '1);
  assign early    = is_div & (div_zero | div_ovf);
  always_comb begin
    if (div_zero) early_res = is_rem ? opp_a : '1;
    else          early_res = is_rem ? '0 : opp_a;
  end
  assign iter = is_mul | (is_div & ~early);
`else
  assign early     = 1'b0;
  assign early_res = '0;
  assign iter      = is_mul;
`endif

  assign acc_res = early ? early_res : sc_res;

  always_comb begin
    state_d = state_q;
    eval_d  = eval_q;
    zero_d  = zero_q;
    start   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      if (iter) begin
        state_d = ST_CALC;
        start   = 1'b1;
      end else begin
        state_d = ST_DONE;
        eval_d  = acc_res;
        zero_d  = (acc_res == '0);
      end
    end else if ((state_q == ST_CALC) && mdu_last) begin
      state_d = ST_DONE;
      eval_d  = mdu_res;
      zero_d  = (mdu_res == '0);
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      eval_q  <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      eval_q  <= eval_d;
      zero_q  <= zero_d;
    end
  end

  mdu_iter #(
    .DATA_W       (DATA_W),
    .BITS_PER_CYC (BITS_PER_CYC)
  ) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (start),
    .is_div (is_div),
    .sgn    (is_sgn),
    .sel_hi (is_rem | (opc == ALU_MULH) | (opc == ALU_MULHU)),
    .a      (opp_a),
    .b      (opp_b),
    .last   (mdu_last),
    .res    (mdu_res)
  );

endmodule
